// File: rtl/dcache_port_arb_pkg.sv
// Shared types for the data-cache port arbiter: FSM states, captured cache
// request, and the CDB writeback packet used by the load return path.
package dcache_port_arb_pkg;

  localparam int XLEN_W         = 32;
  localparam int TAG_WIDTH      = 6;
  localparam int STARVE_MAX_DEF = 4;

  // Memory-op funct3 encodings (loads and stores share the size field)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    DP_IDLE    = 2'd0,
    DP_LD_REQ  = 2'd1,
    DP_LD_WAIT = 2'd2,
    DP_ST_REQ  = 2'd3
  } dport_state_e;

  typedef struct packed {
    logic                 we;
    logic [XLEN_W-1:0]    addr;
    logic [XLEN_W-1:0]    wdata;
    logic [3:0]           wstrb;
  } dcache_req_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic [XLEN_W-1:0]    result;
  } writeback_packet_t;

endpackage

// File: rtl/dcache_port_arb_mem_size_fmt.sv
// Combinational size formatting: store strobe/lane replication and load
// align/extend for byte, halfword and word accesses.
module mem_size_fmt
  import dcache_port_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ld_result
);

  logic [XLEN-1:0] shifted;

  // Store side: replicate the sub-word across every lane, strobe the addressed one
  always_comb begin
    wdata = st_data;
    wstrb = 4'b1111;
    case (st_funct3)
      F3_B: begin
        wdata = {(XLEN/8){st_data[7:0]}};
        wstrb = 4'b0001 << st_off;
      end
      F3_H: begin
        wdata = {(XLEN/16){st_data[15:0]}};
        wstrb = 4'b0011 << st_off;
      end
      default: begin
        wdata = st_data;
        wstrb = 4'b1111;
      end
    endcase
  end

  // Load side: bring the addressed bytes to bit 0, then extend
  always_comb begin
    shifted   = rdata >> {ld_off, 3'b000};
    ld_result = shifted;
    case (ld_funct3)
      F3_B:    ld_result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    ld_result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   ld_result = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   ld_result = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ld_result = shifted;
    endcase
  end

endmodule

// File: rtl/dcache_port_arb.sv
// Single data-cache port shared by load issue and committed-store drain:
// arbitrates, sequences one cache transaction at a time, returns loads on the CDB.
module dcache_port_arb
  import dcache_port_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int XLEN       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 ld_req_valid,
  output logic                 ld_req_ready,
  input  logic [XLEN-1:0]      ld_req_addr,
  input  logic [2:0]           ld_req_funct3,
  input  logic [TAG_WIDTH-1:0] ld_req_tag,
  input  logic                 st_req_valid,
  output logic                 st_req_ready,
  input  logic [XLEN-1:0]      st_req_addr,
  input  logic [XLEN-1:0]      st_req_data,
  input  logic [2:0]           st_req_funct3,
  input  logic                 st_q_full,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_we,
  output logic [XLEN-1:0]      mem_req_addr,
  output logic [XLEN-1:0]      mem_req_wdata,
  output logic [3:0]           mem_req_wstrb,
  input  logic                 mem_resp_valid,
  input  logic [XLEN-1:0]      mem_resp_rdata,
  output writeback_packet_t    ld_wb,
  output logic                 port_busy
);

  dport_state_e         state, state_nxt;
  dcache_req_t          req;
  logic [2:0]           starve_cnt;
  logic                 drop;
  logic                 store_win;
  logic [2:0]           ld_f3;
  logic [1:0]           ld_off;
  logic [TAG_WIDTH-1:0] ld_tag;
  logic [XLEN-1:0]      st_wdata;
  logic [3:0]           st_wstrb;
  logic [XLEN-1:0]      ld_result;

  mem_size_fmt #(.XLEN(XLEN)) u_fmt (
    .st_funct3 (st_req_funct3),
    .st_off    (st_req_addr[1:0]),
    .st_data   (st_req_data),
    .wdata     (st_wdata),
    .wstrb     (st_wstrb),
    .ld_funct3 (ld_f3),
    .ld_off    (ld_off),
    .rdata     (mem_resp_rdata),
    .ld_result (ld_result)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DP_IDLE;
    else      state <= state_nxt;
  end

  // Arbitration, handshakes and next state; readies are held low while in reset
  always_comb begin
    state_nxt    = state;
    store_win    = 1'b0;
    ld_req_ready = 1'b0;
    st_req_ready = 1'b0;
    case (state)
      DP_IDLE: begin
        store_win    = st_req_valid &&
                       (!ld_req_valid || st_q_full || (starve_cnt == 3'(STARVE_MAX)));
        st_req_ready = rst && store_win;
        ld_req_ready = rst && ld_req_valid && !store_win && !flush;
        if (st_req_ready)      state_nxt = DP_ST_REQ;
        else if (ld_req_ready) state_nxt = DP_LD_REQ;
        else                   state_nxt = DP_IDLE;
      end
      DP_LD_REQ: begin
        if (flush)              state_nxt = DP_IDLE;
        else if (mem_req_ready) state_nxt = DP_LD_WAIT;
        else                    state_nxt = DP_LD_REQ;
      end
      DP_LD_WAIT: begin
        if (mem_resp_valid) state_nxt = DP_IDLE;
        else                state_nxt = DP_LD_WAIT;
      end
      DP_ST_REQ: begin
        if (mem_req_ready) state_nxt = DP_IDLE;
        else               state_nxt = DP_ST_REQ;
      end
      default: state_nxt = DP_IDLE;
    endcase
    // A flushed load must never reach the cache, even on its accept cycle
    mem_req_valid = (state == DP_ST_REQ) || ((state == DP_LD_REQ) && !flush);
  end

  // Load-over-store starvation counter, only evaluated while arbitrating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= 3'd0;
    end else if (state == DP_IDLE) begin
      if (st_req_ready || !st_req_valid)             starve_cnt <= 3'd0;
      else if (ld_req_ready && starve_cnt != 3'd7)   starve_cnt <= starve_cnt + 3'd1;
      else                                           starve_cnt <= starve_cnt;
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

  // Request capture on the granting handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req    <= '0;
      ld_f3  <= 3'b000;
      ld_off <= 2'b00;
      ld_tag <= '0;
    end else if (st_req_ready) begin
      req.we    <= 1'b1;
      req.addr  <= {st_req_addr[XLEN-1:2], 2'b00};
      req.wdata <= st_wdata;
      req.wstrb <= st_wstrb;
    end else if (ld_req_ready) begin
      req.we    <= 1'b0;
      req.addr  <= {ld_req_addr[XLEN-1:2], 2'b00};
      req.wdata <= '0;
      req.wstrb <= 4'b0000;
      ld_f3     <= ld_req_funct3;
      ld_off    <= ld_req_addr[1:0];
      ld_tag    <= ld_req_tag;
    end
  end

  // Drop flag and registered CDB writeback; a flushed load still consumes its response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop  <= 1'b0;
      ld_wb <= '0;
    end else begin
      ld_wb.valid <= 1'b0;
      if (state == DP_LD_WAIT) begin
        if (mem_resp_valid) begin
          drop <= 1'b0;
          if (!drop && !flush) begin
            ld_wb.valid  <= 1'b1;
            ld_wb.tag    <= ld_tag;
            ld_wb.result <= ld_result;
          end
        end else if (flush) begin
          drop <= 1'b1;
        end
      end else begin
        drop <= 1'b0;
      end
    end
  end

  assign mem_req_we    = req.we;
  assign mem_req_addr  = req.addr;
  assign mem_req_wdata = req.wdata;
  assign mem_req_wstrb = req.wstrb;
  assign port_busy     = (state != DP_IDLE);

endmodule
